// File: rtl/serdes_pkg.sv
// Shared definitions for the fabric serializer and the receiver-side aligner,
// so both ends agree on frame sources and the idle/training patterns.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DATA  = 2'd2
  } frame_src_t;

  localparam logic [7:0] DEFAULT_IDLE_WORD  = 8'h00;
  // Aperiodic within a frame, so any rotation of it is unique.
  localparam logic [7:0] DEFAULT_TRAIN_WORD = 8'hB4;

  localparam int MIN_DATA_WIDTH = 2;
  localparam int MAX_DATA_WIDTH = 16;

  function automatic logic is_data_frame(input frame_src_t src);
    return src == DATA;
  endfunction

endpackage

// File: rtl/serdes_hold_reg.sv
// One-entry valid/ready holding register. A drain frees the entry in the same
// edge, so a simultaneous drain and refill is accepted.
module serdes_hold_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  drain,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_full
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign in_ready  = !full_q || drain;
  assign hold_data = data_q;
  assign hold_full = full_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (drain) begin
      full_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/oserdes_tx.sv
// Fabric N:1 serializer: gapless MSB-first frames of data, idle or training
// words, with a one-entry holding register in front of the shifter.
module oserdes_tx
  import serdes_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(DEFAULT_IDLE_WORD),
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD = DATA_WIDTH'(DEFAULT_TRAIN_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  train,
  output logic                  ser_out,
  output logic                  frame_start,
  output logic [1:0]            frame_src,
  output logic                  underrun
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  frame_src_t            frame_src_q, frame_src_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;

  logic                  load;
  logic                  bypass;
  logic                  drain;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_in_ready;

  assign load   = (bit_cnt_q == LAST_BIT);
  assign drain  = load && !train && hold_full;
  // An empty holding register at an untrained boundary lets the word skip it.
  assign bypass = load && !train && !hold_full && in_valid;

  serdes_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid && !bypass),
    .in_ready  (hold_in_ready),
    .drain     (drain),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  always_comb begin
    shift_d       = shift_q << 1;
    bit_cnt_d     = bit_cnt_q + 1'b1;
    frame_src_d   = frame_src_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    if (load) begin
      bit_cnt_d     = '0;
      frame_start_d = 1'b1;
      if (train) begin
        shift_d     = TRAIN_WORD;
        frame_src_d = TRAIN;
      end else if (hold_full) begin
        shift_d     = hold_data;
        frame_src_d = DATA;
      end else if (in_valid) begin
        shift_d     = in_data;
        frame_src_d = DATA;
      end else begin
        shift_d     = IDLE_WORD;
        frame_src_d = IDLE;
        underrun_d  = is_data_frame(frame_src_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= LAST_BIT;
      frame_src_q   <= IDLE;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_src_q   <= frame_src_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign in_ready    = hold_in_ready;
  assign ser_out     = shift_q[DATA_WIDTH-1];
  assign frame_start = frame_start_q;
  assign frame_src   = frame_src_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_oserdes_tx.sv
// Directed and randomized bench for oserdes_tx against a frame-level model:
// a queue of pending words and one frame chosen at every DATA_WIDTH-th edge.
module tb_oserdes_tx;

  localparam logic [7:0] EXP_IDLE  = 8'h00;
  localparam logic [7:0] EXP_TRAIN = 8'hB4;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       train;
  logic       ser_out;
  logic       frame_start;
  logic [1:0] frame_src;
  logic       underrun;

  oserdes_tx dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .train       (train),
    .ser_out     (ser_out),
    .frame_start (frame_start),
    .frame_src   (frame_src),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: edges counted since reset release; every 8th is a boundary.
  int         cyc;
  logic [7:0] pend[$];
  logic [7:0] cur_word;
  int         cur_src;
  logic       last_accept;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    cyc         = 0;
    pend.delete();
    cur_word    = 8'h00;
    cur_src     = 0;
    last_accept = 1'b0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ser_out", 32'(ser_out), 32'd0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_frame_src", 32'(frame_src), 32'd0);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic t);
    logic is_load, exp_ready, accepted, bypassed, exp_underrun;
    int   prev_src;
    in_valid = v;
    in_data  = d;
    train    = t;
    #1;
    is_load   = (cyc % 8 == 0);
    exp_ready = (pend.size() == 0) || (is_load && !t);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    accepted     = v && exp_ready;
    bypassed     = 1'b0;
    exp_underrun = 1'b0;
    if (is_load) begin
      prev_src = cur_src;
      if (t) begin
        cur_word = EXP_TRAIN; cur_src = 1;
      end else if (pend.size() > 0) begin
        cur_word = pend.pop_front(); cur_src = 2;
      end else if (accepted) begin
        cur_word = d; cur_src = 2; bypassed = 1'b1;
      end else begin
        cur_word = EXP_IDLE; cur_src = 0;
        exp_underrun = (prev_src == 2);
      end
    end
    if (accepted && !bypassed) pend.push_back(d);
    last_accept = accepted;
    @(posedge clk);
    #1;
    checkOutput("ser_out", 32'(ser_out), 32'(cur_word[7 - (cyc % 8)]));
    checkOutput("frame_start", 32'(frame_start), 32'(is_load));
    checkOutput("frame_src", 32'(frame_src), 32'(cur_src));
    checkOutput("underrun", 32'(underrun), 32'(exp_underrun));
    cyc++;
  endtask

  task automatic idleUntil(input int phase);
    while (cyc % 8 != phase) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] stream_words [4];
    logic [7:0] rnd_word;
    logic       rnd_valid, rnd_train;
    int         idx, guard;

    stream_words = '{8'h01, 8'h80, 8'hFF, 8'h00};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; train = 1'b0;
    modelReset();

    // Reset, then idle frames.
    #12;
    checkResetOutputs();
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0);

    // Bypass of 8'hC5 at a boundary, then the IDLE frame that underruns.
    idleUntil(0);
    applyStimulus(1'b1, 8'hC5, 1'b0);
    checkOutput("c5_accepted", 32'(last_accept), 32'd1);
    repeat (15) applyStimulus(1'b0, 8'h00, 1'b0);

    // Continuous stream with in_valid held high.
    idx = 0; guard = 0;
    while (idx < 4 && guard < 100) begin
      applyStimulus(1'b1, stream_words[idx], 1'b0);
      if (last_accept) idx++;
      guard++;
    end
    checkOutput("stream_all_accepted", 32'(idx), 32'd4);
    repeat (24) applyStimulus(1'b0, 8'h00, 1'b0);

    // Hold 8'h3C mid-frame, then train for three frames.
    idleUntil(3);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    idleUntil(0);
    repeat (24) applyStimulus(1'b1, 8'h77, 1'b1);
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0);

    // Train raised mid-way through a DATA frame.
    idleUntil(0);
    applyStimulus(1'b1, 8'hA6, 1'b0);
    idleUntil(3);
    repeat (13) applyStimulus(1'b0, 8'h00, 1'b1);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b0);

    // Randomized traffic, source holds each word until accepted.
    rnd_word = 8'($urandom); rnd_valid = 1'b0; rnd_train = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!rnd_valid || last_accept) begin
        rnd_word  = 8'($urandom);
        rnd_valid = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 19) == 0) rnd_train = !rnd_train;
      applyStimulus(rnd_valid, rnd_word, rnd_train);
    end
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset at bit 3 of a DATA frame with the holding register full.
    idleUntil(0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b0);
    checkOutput("hold_filled", 32'(pend.size()), 32'd1);
    idleUntil(4);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs();
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    repeat (16) applyStimulus(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
